// File: rtl/para_bank_loader.sv
// rtl/para_bank_loader.sv - double-buffered layer parameter loader with frame-boundary bank swap
//
// Purpose: streams per-layer parameter words into a shadow bank while the
// datapath reads a stable active bank. A fully loaded shadow is promoted to
// active on verticle_sync. Lanes beyond the runtime counts read as zero.
//
// Ports:
//   clk             clock
//   rstn            synchronous reset, active-high
//   mode_in         load mode; rising edge starts a load, low mid-load aborts
//   para_in_valid   para_in word qualifier
//   para_in         signed parameter word
//   cfg_fm_depth    active rsign lane count, latched at load start
//   cfg_channel_num active channel count, latched at load start
//   verticle_sync   frame boundary pulse, swap point
//   rsign_para      active rsign bank (FM_DEPTH lanes)
//   bn_a..zeta      active channel banks (CHANNEL_NUM lanes each)
//   shadow_ready    shadow bank loaded, awaiting swap
//   swap_done       one-cycle pulse when the active bank changes
//   load_err        one-cycle pulse on abort or overrun
module para_bank_loader #(
    parameter int FM_DEPTH        = 64,
    parameter int CHANNEL_NUM     = 128,
    parameter int PARA_WIDTH      = 16,
    parameter int LOG2CHANNEL_NUM = 7,
    parameter int PARA_NUM        = 6
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     mode_in,
    input  logic                                     para_in_valid,
    input  logic signed [PARA_WIDTH-1:0]             para_in,
    input  logic [LOG2CHANNEL_NUM:0]                 cfg_fm_depth,
    input  logic [LOG2CHANNEL_NUM:0]                 cfg_channel_num,
    input  logic                                     verticle_sync,
    output logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]      rsign_para,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0]   bn_a,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0]   bn_b,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0]   beta,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0]   gamma,
    output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0]   zeta,
    output logic                                     shadow_ready,
    output logic                                     swap_done,
    output logic                                     load_err
);

    localparam int CW  = LOG2CHANNEL_NUM + 1;
    localparam int NCG = PARA_NUM - 1;          // channel-wide groups after rsign
    localparam int FW  = $clog2(FM_DEPTH);
    localparam int GW  = $clog2(NCG);
    localparam logic [CW-1:0] FM_MAX = CW'(FM_DEPTH);
    localparam logic [CW-1:0] CH_MAX = CW'(CHANNEL_NUM);

    typedef enum logic [2:0] {
        IDLE, LD_RSIGN, LD_BNA, LD_BNB, LD_BETA, LD_GAMMA, LD_ZETA, READY
    } state_e;

    state_e                      state_q, state_d;
    logic [LOG2CHANNEL_NUM-1:0]  idx_q, idx_d;
    logic [CW-1:0]               fm_q, fm_d;
    logic [CW-1:0]               ch_q, ch_d;
    logic                        mode_q;
    logic                        shadow_ready_q;
    logic                        swap_done_q;
    logic                        load_err_q;

    logic                        mode_rise;
    logic                        wr_en;
    logic                        swap;
    logic                        load_err_d;
    logic [CW-1:0]               cfg_cur;
    logic [GW-1:0]               grp;

    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]    sh_rsign_q;
    logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] sh_ch_q  [NCG];
    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]    act_rsign_q;
    logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] act_ch_q [NCG];

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic [CW-1:0] mx);
        return ((v == '0) || (v > mx)) ? mx : v;
    endfunction

    assign mode_rise = mode_in & ~mode_q;
    // LD_BNA..LD_ZETA are consecutive encodings, so the offset is the group number
    assign grp = GW'(3'(state_q) - 3'(LD_BNA));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fm_d       = fm_q;
        ch_d       = ch_q;
        wr_en      = 1'b0;
        swap       = 1'b0;
        load_err_d = 1'b0;
        cfg_cur    = (state_q == LD_RSIGN) ? fm_q : ch_q;
        unique case (state_q)
            IDLE: begin
                if (mode_rise) begin
                    state_d = LD_RSIGN;
                    idx_d   = '0;
                    fm_d    = clamp(cfg_fm_depth, FM_MAX);
                    ch_d    = clamp(cfg_channel_num, CH_MAX);
                end
            end
            READY: begin
                // swap has priority over a coincident restart edge
                if (verticle_sync) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end else if (mode_rise) begin
                    state_d = LD_RSIGN;
                    idx_d   = '0;
                    fm_d    = clamp(cfg_fm_depth, FM_MAX);
                    ch_d    = clamp(cfg_channel_num, CH_MAX);
                end else if (mode_in && para_in_valid) begin
                    load_err_d = 1'b1;
                end
            end
            default: begin
                if (!mode_in) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    load_err_d = 1'b1;
                end else if (para_in_valid) begin
                    wr_en = 1'b1;
                    if ({1'b0, idx_q} == cfg_cur - CW'(1)) begin
                        idx_d   = '0;
                        state_d = state_e'(3'(state_q) + 3'd1);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            fm_q           <= '0;
            ch_q           <= '0;
            mode_q         <= 1'b0;
            shadow_ready_q <= 1'b0;
            swap_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            fm_q           <= fm_d;
            ch_q           <= ch_d;
            mode_q         <= mode_in;
            shadow_ready_q <= (state_d == READY);
            swap_done_q    <= swap;
            load_err_q     <= load_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            sh_rsign_q  <= '0;
            act_rsign_q <= '0;
            for (int g = 0; g < NCG; g++) begin
                sh_ch_q[g]  <= '0;
                act_ch_q[g] <= '0;
            end
        end else begin
            if (wr_en) begin
                if (state_q == LD_RSIGN) begin
                    sh_rsign_q[idx_q[FW-1:0]] <= para_in;
                end else begin
                    sh_ch_q[grp][idx_q] <= para_in;
                end
            end
            if (swap) begin
                for (int i = 0; i < FM_DEPTH; i++) begin
                    act_rsign_q[i] <= (CW'(i) < fm_q) ? sh_rsign_q[i] : '0;
                end
                for (int g = 0; g < NCG; g++) begin
                    for (int i = 0; i < CHANNEL_NUM; i++) begin
                        act_ch_q[g][i] <= (CW'(i) < ch_q) ? sh_ch_q[g][i] : '0;
                    end
                end
            end
        end
    end

    assign rsign_para   = act_rsign_q;
    assign bn_a         = act_ch_q[0];
    assign bn_b         = act_ch_q[1];
    assign beta         = act_ch_q[2];
    assign gamma        = act_ch_q[3];
    assign zeta         = act_ch_q[4];
    assign shadow_ready = shadow_ready_q;
    assign swap_done    = swap_done_q;
    assign load_err     = load_err_q;

endmodule
